// File: rtl/sine_dac_spi.sv
// rtl/sine_dac_spi.sv - sine word to offset-binary code, serialised as a 16-bit SPI DAC frame
// Optional feature macro: SINE_DAC_LDAC_EN (pulses dac_ldac_n low in the gap after each frame)
module sine_dac_spi #(
   parameter int         DAC_BITS      = 12,
   parameter logic [3:0] CMD           = 4'b0011,
   parameter int         SCLK_DIV      = 4,
   parameter int         SAMPLE_PERIOD = 1000,
   parameter int         CS_GAP        = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [31:0]         sin_in,
   output logic                dac_cs_n,
   output logic                dac_sclk,
   output logic                dac_mosi,
   output logic                dac_ldac_n,
   output logic                busy,
   output logic                overrun,
   output logic [DAC_BITS-1:0] last_code
);

`ifdef SINE_DAC_LDAC_EN
   localparam int GAP_LEN = (CS_GAP > 2*SCLK_DIV+1) ? CS_GAP : 2*SCLK_DIV+1;
   localparam logic [15:0] LDAC_LEN = 16'(2*SCLK_DIV);
`else
   localparam int GAP_LEN = CS_GAP;
`endif
   localparam logic [19:0] TICK_AT = 20'(SAMPLE_PERIOD-1);
   localparam logic [15:0] DIV_END = 16'(SCLK_DIV-1);
   localparam logic [15:0] GAP_END = 16'(GAP_LEN-1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t      state;
   state_t      state_next;
   logic [19:0] timer;
   logic        tick;
   logic [15:0] div_cnt;
   logic [4:0]  half_cnt;
   logic [15:0] gap_cnt;
   logic [15:0] shreg;
   logic [11:0] scaled;
   logic [11:0] code;
   logic        div_done;
   logic        last_half;
   logic        gap_done;
   logic        unused_bits;

   // Fractional bits below the 12-bit DAC resolution are deliberately dropped.
   assign unused_bits = ^sin_in[13:0];

   // Free-running sample timer; tick on its terminal count.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         timer <= '0;
      end else if (timer == TICK_AT) begin
         timer <= '0;
      end else begin
         timer <= timer + 20'd1;
      end
   end

   assign tick = (timer == TICK_AT);

   // Sign-magnitude to offset-binary, magnitude clamped to 2047 (|x| >= 1.0 saturates).
   always_comb begin
      scaled = {1'b0, sin_in[24:14]};
      if (|sin_in[30:25]) begin
         scaled = 12'd2047;
      end
      code = sin_in[31] ? (12'd2048 - scaled) : (12'd2048 + scaled);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-state terminal conditions.
   always_comb begin
      state_next = state;
      div_done   = (div_cnt == DIV_END);
      last_half  = (half_cnt == 5'd31);
      gap_done   = (gap_cnt == GAP_END);
      case (state)
         IDLE:    if (tick) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (div_done && last_half) state_next = GAP;
         GAP:     if (gap_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Capture, SPI serialisation, gap timing and status flags.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         dac_cs_n   <= 1'b1;
         dac_sclk   <= 1'b0;
         dac_mosi   <= 1'b0;
         dac_ldac_n <= 1'b1;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         last_code  <= 12'h800;
         shreg      <= '0;
         div_cnt    <= '0;
         half_cnt   <= '0;
         gap_cnt    <= '0;
      end else begin
         // A tick while a frame is in flight (including its last gap cycle) is dropped.
         if (tick && state != IDLE) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (tick) begin
                  shreg     <= {CMD, code};
                  last_code <= code;
                  busy      <= 1'b1;
               end
            end
            LOAD: begin
               dac_cs_n <= 1'b0;
               dac_mosi <= shreg[15];
               dac_sclk <= 1'b0;
               div_cnt  <= '0;
               half_cnt <= '0;
               gap_cnt  <= '0;
            end
            SHIFT: begin
               if (div_done) begin
                  div_cnt <= '0;
                  if (last_half) begin
                     // Trailing half-period after the 16th rising edge ends the frame.
                     dac_sclk <= 1'b0;
                     dac_cs_n <= 1'b1;
                     dac_mosi <= 1'b0;
                     gap_cnt  <= '0;
                  end else begin
                     half_cnt <= half_cnt + 5'd1;
                     dac_sclk <= ~dac_sclk;
                     if (dac_sclk) begin
                        shreg    <= {shreg[14:0], 1'b0};
                        dac_mosi <= shreg[14];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            GAP: begin
               if (gap_done) begin
                  busy <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            default: ;
         endcase
`ifdef SINE_DAC_LDAC_EN
         dac_ldac_n <= !((state == GAP) && (gap_cnt < LDAC_LEN));
`else
         dac_ldac_n <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_sine_dac_spi.sv
// tb/tb_sine_dac_spi.sv - directed bench for sine_dac_spi (SINE_DAC_LDAC_EN aware)
module tb_sine_dac_spi;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] sin_a = 32'h0000_0000;
   logic [31:0] sin_b = 32'h8100_0000;
   logic        cs_a, sclk_a, mosi_a, ldac_a, busy_a, ovr_a;
   logic        cs_b, sclk_b, mosi_b, ldac_b, busy_b, ovr_b;
   logic [11:0] code_a, code_b;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

`ifdef SINE_DAC_LDAC_EN
   localparam int EXP_LDAC_LOW = 4;
   localparam int EXP_LDAC_FIRST = 1;
   localparam int EXP_BUSY_FALL = 5;
`else
   localparam int EXP_LDAC_LOW = 0;
   localparam int EXP_LDAC_FIRST = -1;
   localparam int EXP_BUSY_FALL = 2;
`endif

   sine_dac_spi #(.DAC_BITS(12), .CMD(4'b0011), .SCLK_DIV(2), .SAMPLE_PERIOD(100), .CS_GAP(2)) dut_a (
      .clock(clock), .reset_n(reset_n), .sin_in(sin_a),
      .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a), .dac_ldac_n(ldac_a),
      .busy(busy_a), .overrun(ovr_a), .last_code(code_a));

   sine_dac_spi #(.DAC_BITS(12), .CMD(4'b0011), .SCLK_DIV(2), .SAMPLE_PERIOD(40), .CS_GAP(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .sin_in(sin_b),
      .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b), .dac_ldac_n(ldac_b),
      .busy(busy_b), .overrun(ovr_b), .last_code(code_b));

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic cs_of(input bit s);   return s ? cs_b : cs_a;     endfunction
   function automatic logic sclk_of(input bit s); return s ? sclk_b : sclk_a; endfunction
   function automatic logic mosi_of(input bit s); return s ? mosi_b : mosi_a; endfunction
   function automatic logic ldac_of(input bit s); return s ? ldac_b : ldac_a; endfunction
   function automatic logic busy_of(input bit s); return s ? busy_b : busy_a; endfunction

   // Records one whole frame (skipping any frame already in progress) plus the gap that follows.
   task automatic grab_frame(input bit s, output logic [15:0] word, output int low_cyc, output int rises,
                             output int start_cyc, output int ldac_low, output int ldac_first, output int busy_fall);
      int  n;
      bit  prev;
      word = '0; low_cyc = 0; rises = 0; start_cyc = 0; ldac_low = 0; ldac_first = -1; busy_fall = -1;
      n = 0;
      while (!cs_of(s) && n < 400) begin
         @(negedge clock);
         n++;
      end
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cs_of(s) && n < 400);
      if (cs_of(s)) begin
         check("frame_timeout", 32'd1, 32'd0);
         return;
      end
      start_cyc = cyc;
      prev = 1'b0;
      while (!cs_of(s) && low_cyc < 400) begin
         low_cyc++;
         if (sclk_of(s) && !prev) begin
            word = {word[14:0], mosi_of(s)};
            rises++;
         end
         prev = sclk_of(s);
         @(negedge clock);
      end
      for (int i = 0; i < 12; i++) begin
         if (!ldac_of(s)) begin
            ldac_low++;
            if (ldac_first < 0) ldac_first = i;
         end
         if (busy_fall < 0 && !busy_of(s)) busy_fall = i;
         @(negedge clock);
      end
   endtask

   task automatic frame_check(input string tag, input logic [15:0] exp_word, input logic [11:0] exp_code);
      logic [15:0] w;
      int lc, r, st, ll, lf, bf;
      grab_frame(1'b0, w, lc, r, st, ll, lf, bf);
      check({tag, "_word"}, {16'h0, w}, {16'h0, exp_word});
      check({tag, "_cs_low"}, lc, 64);
      check({tag, "_rises"}, r, 16);
      check({tag, "_last_code"}, {20'h0, code_a}, {20'h0, exp_code});
      check({tag, "_ldac_low"}, ll, EXP_LDAC_LOW);
      check({tag, "_ldac_first"}, lf, EXP_LDAC_FIRST);
      check({tag, "_busy_fall"}, bf, EXP_BUSY_FALL);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] w1, w2;
      int lc1, lc2, r1, r2, st1, st2, ll, lf, bf, n;

      repeat (3) @(negedge clock);
      check("rst_cs_n", cs_a, 1'b1);
      check("rst_sclk", sclk_a, 1'b0);
      check("rst_mosi", mosi_a, 1'b0);
      check("rst_ldac_n", ldac_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_overrun", ovr_a, 1'b0);
      check("rst_last_code", {20'h0, code_a}, 32'h800);

      reset_n = 1'b1;
      n = 0;
      while (!busy_a && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("first_tick_latency", n, 100);

      frame_check("zero", 16'h3800, 12'h800);
      sin_a = 32'h0200_0000;
      frame_check("pos_one", 16'h3FFF, 12'hFFF);
      sin_a = 32'h7E00_0000;
      frame_check("pos_big", 16'h3FFF, 12'hFFF);
      sin_a = 32'h8100_0000;
      frame_check("neg_half", 16'h3400, 12'h400);
      sin_a = 32'h8200_0000;
      frame_check("neg_one", 16'h3001, 12'h001);
      check("ovr_a_clean", ovr_a, 1'b0);

      check("ovr_b_set", ovr_b, 1'b1);
      grab_frame(1'b1, w1, lc1, r1, st1, ll, lf, bf);
      grab_frame(1'b1, w2, lc2, r2, st2, ll, lf, bf);
      check("ovr_b_word1", {16'h0, w1}, 32'h3400);
      check("ovr_b_word2", {16'h0, w2}, 32'h3400);
      check("ovr_b_cs_low", lc2, 64);
      check("ovr_b_period", st2 - st1, 80);
      check("ovr_b_sticky", ovr_b, 1'b1);
      check("ovr_b_code", {20'h0, code_b}, 32'h400);

      n = 0;
      while (cs_a && n < 400) begin
         @(negedge clock);
         n++;
      end
      r1 = 0;
      n = 0;
      begin
         bit prev;
         prev = 1'b0;
         while (r1 < 7 && n < 400) begin
            if (sclk_a && !prev) r1++;
            prev = sclk_a;
            if (r1 < 7) begin
               @(negedge clock);
               n++;
            end
         end
      end
      check("midrst_reach_7th_rise", r1, 7);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check("midrst_cs_n", cs_a, 1'b1);
      check("midrst_sclk", sclk_a, 1'b0);
      check("midrst_busy", busy_a, 1'b0);
      check("midrst_last_code", {20'h0, code_a}, 32'h800);
      check("midrst_ovr_b_clear", ovr_b, 1'b0);
      n = 0;
      for (int i = 0; i < 90; i++) begin
         @(negedge clock);
         if (sclk_a || !cs_a) n++;
      end
      check("midrst_quiet", n, 0);
      frame_check("after_rst", 16'h3001, 12'h001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
